// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream byte packing/unpacking path.
package axis_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_BUSY  = 1'b1
    } state_t;

    // Width of a byte index into an n-byte word; never narrower than one bit.
    function automatic int idx_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/axis_word_unpacker.sv
// AXI-Stream downsizer: one nb-bit word in, n byte beats out, least-significant byte first.
module axis_word_unpacker
    import axis_pkg::*;
#(
    parameter int  n  = 5,
    localparam int nb = n * BYTE_W
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [nb-1:0]     in_tdata,
    input  logic              in_tlast,
    input  logic              in_tvalid,
    output logic              in_tready,
    output logic [BYTE_W-1:0] out_tdata,
    output logic              out_tlast,
    output logic              out_tvalid,
    input  logic              out_tready
);

    localparam int             IW       = idx_width(n);
    localparam logic [IW-1:0]  IDX_LAST = IW'(n - 1);

    state_t          state_reg;
    logic [nb-1:0]   hold_reg;
    logic            last_reg;
    logic [IW-1:0]   idx_reg;

    logic            at_last;
    logic            in_fire;
    logic            busy;

    assign busy    = (state_reg == ST_BUSY);
    assign at_last = (idx_reg == IDX_LAST);

    // Ready on the final byte lets the next word land without a bubble.
    assign in_tready  = aresetn && (!busy || (at_last && out_tready));
    assign in_fire    = in_tvalid && in_tready;

    assign out_tvalid = busy;
    assign out_tdata  = hold_reg[BYTE_W*idx_reg +: BYTE_W];
    assign out_tlast  = busy && at_last && last_reg;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg <= ST_EMPTY;
            hold_reg  <= '0;
            last_reg  <= 1'b0;
            idx_reg   <= '0;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_fire) begin
                        hold_reg  <= in_tdata;
                        last_reg  <= in_tlast;
                        idx_reg   <= '0;
                        state_reg <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (out_tready) begin
                        if (!at_last) begin
                            idx_reg <= idx_reg + 1'b1;
                        end else if (in_fire) begin
                            hold_reg <= in_tdata;
                            last_reg <= in_tlast;
                            idx_reg  <= '0;
                        end else begin
                            idx_reg   <= '0;
                            state_reg <= ST_EMPTY;
                        end
                    end
                end
                default: state_reg <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: doc/axis_word_unpacker.md
Name: axis_word_unpacker

Overview:
- AXI-Stream downsizer: accepts one nb-bit word per handshake and emits it as n consecutive 8-bit beats, least-significant byte first.
- The reverse end of the team's byte-packing stream path: feeds byte-wide consumers (UART/SPI TX, byte FIFOs) from word-wide producers, typically behind a skid_buffer.
- Full throughput: no bubble between words when both sides stream continuously.

Parameters:
- n, 5, bytes per input word; legal range n >= 1.
- nb, n*8, input data width; derived, never overridden independently.

Ports:
- aclk  input  1  clock; all logic on rising edge.
- aresetn  input  1  reset, synchronous, active-low.
- in_tdata  input  nb  word to unpack.
- in_tlast  input  1  word is last of packet.
- in_tvalid  input  1  word valid.
- in_tready  output  1  unpacker accepts word this cycle.
- out_tdata  output  8  current byte.
- out_tlast  output  1  last byte of a packet.
- out_tvalid  output  1  byte valid.
- out_tready  input  1  downstream accepts byte.

Behaviour:
- Reset (aresetn=0 at a clock edge): out_tvalid=0, out_tlast=0, out_tdata=0, byte index=0, holding register cleared. in_tready is forced to 0 while aresetn=0. Reset wins over any handshake in the same cycle; a partially sent word is discarded.
- Storage: holding register (nb bits, plus stored tlast) and byte index idx, counting 0..n-1.
- States:
  - EMPTY: out_tvalid=0.
  - BUSY: out_tvalid=1; out_tdata = hold[8*idx +: 8].
- in_tready = EMPTY, or (BUSY and idx==n-1 and out_tready). This is a combinational path from out_tready, accepted by design; place a skid_buffer downstream if timing requires.
- out_tlast = BUSY and idx==n-1 and stored tlast. It is 0 on all other bytes.
- Transitions:
  - EMPTY, with in handshake -> BUSY: capture word and tlast, idx=0. Latency: first byte valid 1 cycle after input handshake.
  - BUSY, out handshake, idx<n-1 -> idx+1.
  - BUSY, out handshake, idx==n-1, with in handshake -> stay BUSY: capture new word, idx=0 (back-to-back).
  - BUSY, out handshake, idx==n-1, no in handshake -> EMPTY, idx=0.
  - BUSY, out_tready=0 -> hold out_tdata, out_tlast and idx stable (AXI-Stream rule: no change while valid and not ready).
- n=1: every word is a single byte; behaves as a registered stage with ready passthrough on the last byte.
- in_tvalid must not depend on in_tready. out_tvalid never depends on out_tready combinationally.
- Throughput: n bytes per word; sustained 1 byte/cycle when out_tready=1 and in_tvalid=1.

Decomposition:
- Package axis_pkg:
  - typedef for the state enum (ST_EMPTY, ST_BUSY).
  - BYTE_W = 8.
  - Function clog2-based index width (max(1, $clog2(n))).
- No sub-module. Byte select is an indexed part-select inside the module. A downstream skid_buffer instance is the integrator's choice, not part of this block.

Test Plan (n=5):
- Single word 0x44_33_22_11_00, tlast=1, out_tready=1:
  - out bytes 00,11,22,33,44 on 5 consecutive cycles starting 1 cycle after input handshake.
  - out_tlast=1 only on byte 44; in_tready=0 during bytes 00..33.
- Two words back-to-back, out_tready=1, second word presented while last byte is sent:
  - 10 consecutive valid bytes with no bubble.
  - in_tready=1 exactly on the 5th byte cycle.
- Backpressure: out_tready=0 for 3 cycles on byte index 2:
  - out_tdata stays 0x22, out_tvalid stays 1, idx does not advance.
  - Sequence resumes with 33,44 after out_tready=1.
- tlast=0 word followed by tlast=1 word:
  - out_tlast=0 on all 5 bytes of word 1; out_tlast=1 only on the final byte of word 2.
- Reset mid-word: aresetn=0 after byte 11 is sent:
  - next cycle out_tvalid=0, in_tready=0.
  - After release, in_tready=1; a new word starts at byte 0 with no remnants of the old word.
- Random in_tvalid/out_tready (10k cycles) with scoreboard:
  - byte stream equals LSB-first unpacked word stream.
  - tlast positions match; no data change while out_tvalid=1 and out_tready=0.
